// File: rtl/tt_io_word_bridge.sv
// Pin-to-core word bridge: byte writes in, byte reads out, host strobes on uio.
// Optional parity check on host bytes with TT_BRIDGE_PARITY_EN.
module tt_io_word_bridge #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       ui_in,
  input  logic [7:0]       uio_in,
  output logic [7:0]       uo_out,
  output logic [7:0]       uio_out,
  output logic [7:0]       uio_oe,
  output logic [IN_W-1:0]  core_in_data,
  output logic             core_in_valid,
  input  logic             core_in_ready,
  input  logic [OUT_W-1:0] core_out_data,
  input  logic             core_out_valid,
  output logic             core_out_ready
);

  localparam int IN_BYTES  = (IN_W + 7) / 8;
  localparam int OUT_BYTES = (OUT_W + 7) / 8;
  localparam int CW = $clog2(IN_BYTES + 1);
  localparam int OW = $clog2(OUT_BYTES + 1);

  typedef enum logic {EMPTY, FULL} ostate_t;

  logic [2:0] s1, s2, s3;
  logic [2:0] rise;
  logic       wr_e, rd_e, sy_e;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= uio_in[2:0];
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign wr_e = rise[0];
  assign rd_e = rise[1];
  assign sy_e = rise[2];

  logic par_ok;
  logic unused_pins;
`ifdef TT_BRIDGE_PARITY_EN
  assign par_ok      = (^ui_in) == uio_in[3];
  assign unused_pins = ^uio_in[7:4];
`else
  assign par_ok      = 1'b1;
  assign unused_pins = ^uio_in[7:3];
`endif

  logic [CW-1:0]         cnt;
  logic [IN_BYTES*8-1:0] slots;
  logic                  err;
  logic                  can_take;
  logic                  take;

  // A handshake in the same cycle frees the word, so the byte still lands.
  assign can_take = !core_in_valid || core_in_ready;
  assign take     = wr_e && can_take && par_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt           <= '0;
      slots         <= '0;
      core_in_valid <= 1'b0;
      err           <= 1'b0;
    end else if (sy_e) begin
      cnt           <= '0;
      core_in_valid <= 1'b0;
      err           <= 1'b0;
    end else begin
      if (core_in_valid && core_in_ready)
        core_in_valid <= 1'b0;
      if (wr_e && !(can_take && par_ok))
        err <= 1'b1;
      if (take) begin
        for (int k = 0; k < IN_BYTES; k++)
          if (cnt == CW'(k))
            slots[k*8 +: 8] <= ui_in;
        if (cnt == CW'(IN_BYTES - 1)) begin
          cnt           <= '0;
          core_in_valid <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign core_in_data = slots[IN_W-1:0];

  generate
    if (IN_BYTES * 8 > IN_W) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^slots[IN_BYTES*8-1:IN_W];
    end
  endgenerate

  ostate_t                st;
  logic [OW-1:0]          idx;
  logic [OUT_BYTES*8-1:0] obuf;
  logic [OUT_BYTES*8-1:0] out_ext;
  logic                   under;

  always_comb begin
    out_ext = '0;
    out_ext[OUT_W-1:0] = core_out_data;
  end

  function automatic logic [7:0] byte_at(
    input logic [OUT_BYTES*8-1:0] w,
    input logic [OW-1:0]          i
  );
    byte_at = 8'h00;
    for (int k = 0; k < OUT_BYTES; k++)
      if (i == OW'(k))
        byte_at = w[k*8 +: 8];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st             <= EMPTY;
      idx            <= '0;
      obuf           <= '0;
      uo_out         <= 8'h00;
      core_out_ready <= 1'b0;
      under          <= 1'b0;
    end else if (sy_e) begin
      st             <= EMPTY;
      idx            <= '0;
      uo_out         <= 8'h00;
      core_out_ready <= 1'b1;
      under          <= 1'b0;
    end else begin
      unique case (st)
        EMPTY: begin
          if (rd_e)
            under <= 1'b1;
          if (core_out_valid && core_out_ready) begin
            obuf           <= out_ext;
            idx            <= '0;
            uo_out         <= out_ext[7:0];
            core_out_ready <= 1'b0;
            st             <= FULL;
          end else begin
            core_out_ready <= 1'b1;
          end
        end
        FULL: begin
          if (rd_e) begin
            if (idx == OW'(OUT_BYTES - 1)) begin
              st             <= EMPTY;
              idx            <= '0;
              uo_out         <= 8'h00;
              core_out_ready <= 1'b1;
            end else begin
              idx    <= idx + 1'b1;
              uo_out <= byte_at(obuf, idx + 1'b1);
            end
          end
        end
        default: st <= EMPTY;
      endcase
    end
  end

  logic oe_on;

  always_ff @(posedge clk) begin
    if (!rst_n) oe_on <= 1'b0;
    else        oe_on <= 1'b1;
  end

  assign uio_oe  = oe_on ? 8'hF0 : 8'h00;
  assign uio_out = {err, under, st == FULL,
                    (cnt != '0) || core_in_valid, 4'b0000};

endmodule
